// File: rtl/mem_line_buffer_if.sv
// Bundles the core word port and the burst physical-memory port of the line buffer.
// The slave modport is the buffer's view; master is the environment (core plus memory).
interface mem_line_buffer_if;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [63:0] pmem_wdata;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/mem_line_buffer.sv
// Single-line write-back buffer: 256-bit line, hits answered in one cycle,
// misses write back a dirty victim and refill as 4 x 64-bit bursts.
module mem_line_buffer (
  input  logic             clk,
  input  logic             rst,
  mem_line_buffer_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WB   = 2'd1;
  localparam logic [1:0] FILL = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]   state;
  logic [1:0]   cnt;
  logic [1:0]   next_cnt;
  logic         valid;
  logic         dirty;
  logic [26:0]  tag;
  logic [255:0] line;
  logic         pending;
  logic [26:0]  req_tag;
  logic [2:0]   req_word;
  logic [26:0]  eff_tag;
  logic [2:0]   eff_word;
  logic         hit;

  // After a miss the held request is finished against the address latched at the miss.
  always_comb begin
    eff_tag  = pending ? req_tag  : bus.mem_address[31:5];
    eff_word = pending ? req_word : bus.mem_address[4:2];
    hit      = valid && (tag == eff_tag);
    next_cnt = cnt + 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      cnt              <= 2'd0;
      valid            <= 1'b0;
      dirty            <= 1'b0;
      tag              <= '0;
      line             <= '0;
      pending          <= 1'b0;
      req_tag          <= '0;
      req_word         <= '0;
      bus.mem_resp     <= 1'b0;
      bus.mem_rdata    <= '0;
      bus.pmem_read    <= 1'b0;
      bus.pmem_write   <= 1'b0;
      bus.pmem_address <= '0;
      bus.pmem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.mem_read || bus.mem_write) begin
            if (hit) begin
              if (bus.mem_write) begin
                for (int i = 0; i < 4; i++) begin
                  if (bus.mem_byte_enable[i])
                    line[{eff_word, 2'(i), 3'b000} +: 8] <= bus.mem_wdata[8*i +: 8];
                end
                dirty <= 1'b1;
              end else begin
                bus.mem_rdata <= line[{eff_word, 5'b00000} +: 32];
              end
              pending      <= 1'b0;
              bus.mem_resp <= 1'b1;
              state        <= RESP;
            end else begin
              pending  <= 1'b1;
              req_tag  <= bus.mem_address[31:5];
              req_word <= bus.mem_address[4:2];
              cnt      <= 2'd0;
              if (valid && dirty) begin
                bus.pmem_write   <= 1'b1;
                bus.pmem_address <= {tag, 5'b00000};
                bus.pmem_wdata   <= line[63:0];
                state            <= WB;
              end else begin
                bus.pmem_read    <= 1'b1;
                bus.pmem_address <= {bus.mem_address[31:5], 5'b00000};
                state            <= FILL;
              end
            end
          end
        end

        WB: begin
          if (bus.pmem_resp) begin
            cnt <= next_cnt;
            if (cnt == 2'd3) begin
              dirty            <= 1'b0;
              bus.pmem_write   <= 1'b0;
              bus.pmem_read    <= 1'b1;
              bus.pmem_address <= {req_tag, 5'b00000};
              state            <= FILL;
            end else begin
              bus.pmem_wdata <= line[{next_cnt, 6'b000000} +: 64];
            end
          end
        end

        FILL: begin
          if (bus.pmem_resp) begin
            line[{cnt, 6'b000000} +: 64] <= bus.pmem_rdata;
            cnt <= next_cnt;
            if (cnt == 2'd3) begin
              valid         <= 1'b1;
              tag           <= req_tag;
              bus.pmem_read <= 1'b0;
              state         <= IDLE;
            end
          end
        end

        RESP: begin
          bus.mem_resp <= 1'b0;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_buffer.sv
// Directed bench for mem_line_buffer with a burst memory model that can insert response gaps.
module tb_mem_line_buffer;

  logic clk;
  logic rst;
  mem_line_buffer_if bus ();

  mem_line_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Memory model state, written only by the model process.
  logic [63:0] pmem_mem [logic [31:0]];
  logic [63:0] wb_log [4];
  logic [31:0] wb_addr = '0;
  logic [31:0] rd_addr = '0;
  int          bcnt = 0;
  int          rd_cycles = 0;
  int          rd_beats = 0;
  int          both_cnt = 0;
  int          consec_cnt = 0;
  logic        prev_resp = 1'b0;
  int          gap_idx = 0;
  logic        gap_mode = 1'b0;
  logic        gap_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  function automatic logic [63:0] default_beat(input logic [31:0] a);
    logic [3:0] h;
    h = a[12] ? (4'd5 + {2'b00, a[4:3]}) : (4'd1 + {2'b00, a[4:3]});
    return {16{h}};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Memory decides the beat strobe at the falling edge; a strobed beat is taken at the next rising edge.
  always @(negedge clk) begin
    logic        resp_now;
    logic [31:0] baddr;
    if (!rst) begin
      bcnt          = 0;
      bus.pmem_resp = 1'b0;
      prev_resp     = 1'b0;
    end else begin
      if (bus.pmem_read && bus.pmem_write) both_cnt++;
      if (bus.mem_resp && prev_resp) consec_cnt++;
      prev_resp = bus.mem_resp;
      assert (!(bus.mem_read && bus.mem_write)) else $error("[TB] read and write requested together");
      if (!gap_mode) gap_idx = 0;
      resp_now = 1'b0;
      if (bus.pmem_read || bus.pmem_write) begin
        if (bus.pmem_read) rd_cycles++;
        if (gap_mode && gap_idx < 7) begin
          resp_now = gap_pat[gap_idx];
          gap_idx++;
        end else begin
          resp_now = 1'b1;
        end
        if (resp_now) begin
          baddr = bus.pmem_address + 32'(bcnt * 8);
          if (bus.pmem_write) begin
            pmem_mem[baddr] = bus.pmem_wdata;
            wb_log[bcnt]    = bus.pmem_wdata;
            wb_addr         = bus.pmem_address;
          end else begin
            bus.pmem_rdata = pmem_mem.exists(baddr) ? pmem_mem[baddr] : default_beat(baddr);
            rd_addr        = bus.pmem_address;
            rd_beats++;
          end
          bcnt = (bcnt + 1) % 4;
        end
      end
      bus.pmem_resp = resp_now;
    end
  end

  task automatic applyStimulus(input logic rd, input logic wr, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wd, output int lat);
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_byte_enable = be;
    bus.mem_address     = addr;
    bus.mem_wdata       = wd;
    lat = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      lat++;
      if (bus.mem_resp) break;
    end
    if (!bus.mem_resp) checkOutput("resp_timeout", 64'(bus.mem_resp), 64'd1);
  endtask

  task automatic idleCycles(input int n);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int lat;
    int rc0;
    int rb0;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_byte_enable = 4'h0;
    bus.mem_address     = '0;
    bus.mem_wdata       = '0;
    bus.pmem_rdata      = '0;
    bus.pmem_resp       = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_mem_resp", 64'(bus.mem_resp), 64'd0);
    checkOutput("rst_pmem_rw", {62'd0, bus.pmem_read, bus.pmem_write}, 64'd0);
    checkOutput("rst_mem_rdata", 64'(bus.mem_rdata), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Clean miss with zero-wait memory.
    rc0 = rd_cycles;
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0000_0044, 32'h0, lat);
    checkOutput("miss_lat", 64'(lat), 64'd6);
    checkOutput("miss_rdata", 64'(bus.mem_rdata), 64'h1111_1111);
    checkOutput("miss_rd_cycles", 64'(rd_cycles - rc0), 64'd4);
    checkOutput("miss_rd_addr", 64'(rd_addr), 64'h40);
    idleCycles(1);

    // Partial write hit; read data register must hold across it.
    applyStimulus(1'b0, 1'b1, 4'b0101, 32'h0000_0048, 32'hDEAD_BEEF, lat);
    checkOutput("wr_hit_lat", 64'(lat), 64'd1);
    checkOutput("wr_rdata_hold", 64'(bus.mem_rdata), 64'h1111_1111);
    idleCycles(1);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0000_0048, 32'h0, lat);
    checkOutput("rd_merge_lat", 64'(lat), 64'd1);
    checkOutput("rd_merge", 64'(bus.mem_rdata), 64'h22AD_22EF);
    idleCycles(1);

    // Dirty miss: write-back of line 0x40, then fill of 0x1040.
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0000_1040, 32'h0, lat);
    checkOutput("dirty_lat", 64'(lat), 64'd10);
    checkOutput("dirty_rdata", 64'(bus.mem_rdata), 64'h5555_5555);
    checkOutput("wb_addr", 64'(wb_addr), 64'h40);
    checkOutput("wb_beat0", wb_log[0], 64'h1111_1111_1111_1111);
    checkOutput("wb_beat1", wb_log[1], 64'h2222_2222_22AD_22EF);
    checkOutput("wb_beat3", wb_log[3], 64'h4444_4444_4444_4444);
    checkOutput("fill_addr", 64'(rd_addr), 64'h1040);
    checkOutput("both_high", 64'(both_cnt), 64'd0);
    idleCycles(1);

    // Fill with gaps in the beat strobe.
    rc0 = rd_cycles;
    rb0 = rd_beats;
    gap_mode = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0000_0048, 32'h0, lat);
    gap_mode = 1'b0;
    checkOutput("gap_lat", 64'(lat), 64'd9);
    checkOutput("gap_rdata", 64'(bus.mem_rdata), 64'h22AD_22EF);
    checkOutput("gap_rd_cycles", 64'(rd_cycles - rc0), 64'd7);
    checkOutput("gap_beats", 64'(rd_beats - rb0), 64'd4);
    idleCycles(1);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0000_005C, 32'h0, lat);
    checkOutput("gap_beat3", 64'(bus.mem_rdata), 64'h4444_4444);
    idleCycles(1);

    // Reset while beat 2 of a fill is on the bus.
    bus.mem_read    = 1'b1;
    bus.mem_address = 32'h0000_2000;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("midrst_pmem_rw", {62'd0, bus.pmem_read, bus.pmem_write}, 64'd0);
    checkOutput("midrst_pmem_addr", 64'(bus.pmem_address), 64'd0);
    checkOutput("midrst_pmem_wdata", bus.pmem_wdata, 64'd0);
    checkOutput("midrst_rdata_resp", {31'd0, bus.mem_resp, bus.mem_rdata}, 64'd0);
    idleCycles(2);
    rst = 1'b1;
    @(negedge clk);
    rc0 = rd_cycles;
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0000_0048, 32'h0, lat);
    checkOutput("refill_lat", 64'(lat), 64'd6);
    checkOutput("refill_cycles", 64'(rd_cycles - rc0), 64'd4);
    checkOutput("refill_rdata", 64'(bus.mem_rdata), 64'h22AD_22EF);

    // Back-to-back hits without idle gaps between requests.
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0000_0040, 32'h0, lat);
    checkOutput("b2b_lat0", 64'(lat), 64'd2);
    checkOutput("b2b_rdata0", 64'(bus.mem_rdata), 64'h1111_1111);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0000_0050, 32'h0, lat);
    checkOutput("b2b_lat1", 64'(lat), 64'd2);
    checkOutput("b2b_rdata1", 64'(bus.mem_rdata), 64'h3333_3333);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0000_0058, 32'h0, lat);
    checkOutput("b2b_rdata2", 64'(bus.mem_rdata), 64'h4444_4444);
    idleCycles(1);
    checkOutput("resp_consecutive", 64'(consec_cnt), 64'd0);

    // Zero byte enables: no data change, but the line still becomes dirty.
    applyStimulus(1'b0, 1'b1, 4'h0, 32'h0000_0050, 32'hFFFF_FFFF, lat);
    checkOutput("be0_lat", 64'(lat), 64'd1);
    idleCycles(1);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0000_0050, 32'h0, lat);
    checkOutput("be0_rdata", 64'(bus.mem_rdata), 64'h3333_3333);
    idleCycles(1);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0000_1044, 32'h0, lat);
    checkOutput("be0_dirty_lat", 64'(lat), 64'd10);
    checkOutput("be0_dirty_rdata", 64'(bus.mem_rdata), 64'h5555_5555);
    idleCycles(1);

    // Partial write to a missing line: fill first, then merge.
    applyStimulus(1'b0, 1'b1, 4'b0011, 32'h0000_004C, 32'h1234_5A5A, lat);
    checkOutput("wmiss_lat", 64'(lat), 64'd6);
    idleCycles(1);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0000_004C, 32'h0, lat);
    checkOutput("wmiss_rdata", 64'(bus.mem_rdata), 64'h2222_5A5A);
    idleCycles(2);
    checkOutput("both_high_end", 64'(both_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
